fft_ctrl: RTL and testbench

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fft_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type and size helpers for the SDF FFT controller
//
// Contents:
//   fft_state_e : controller state (IDLE / RUN / FLUSH)
//   fft_n       : FFT size N from log2(N)
//   fft_lat     : advances from an input sample to its output (N-1 SDF delay + pipe regs)
//   sat_inc     : saturating increment shared by the fill and drain counters
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fft_state_e;

  function automatic int fft_n(input int log2n);
    return 1 << log2n;
  endfunction

  function automatic int fft_lat(input int log2n, input int pipe_lat);
    return fft_n(log2n) - 1 + pipe_lat;
  endfunction

  function automatic int sat_inc(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

endpackage

// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - frame/flush controller for a radix-2^2 SDF FFT datapath
//
// Optional feature macro: FFT_CTRL_AUTOFLUSH_EN (auto-drain when the input goes
// idle right after a frame's last sample).
//
// Ports:
//   aclk, areset_n       : clock (rising edge), asynchronous active-low reset
//   s_valid, s_last      : input sample handshake, last sample of a frame
//   s_ready              : high in IDLE/RUN, low while draining
//   flush_req            : pulse; drain the pipeline after the current frame
//   dp_en                : datapath advance strobe (every SDF stage shifts)
//   dp_cnt               : sample index for BF2I/BF2II selects and twiddle address
//   dp_flush             : datapath inputs forced to zero (drain in progress)
//   m_valid, m_last      : output sample valid, last sample of an output frame
//   m_idx                : output index (bit-reversed order position)
//   frame_err            : one-cycle pulse on s_last / dp_cnt misalignment
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N    = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             flush_req,
  output logic             dp_en,
  output logic [LOG2N-1:0] dp_cnt,
  output logic             dp_flush,
  output logic             m_valid,
  output logic             m_last,
  output logic [LOG2N-1:0] m_idx,
  output logic             frame_err
);

  localparam int N      = fft_n(LOG2N);
  localparam int LAT    = fft_lat(LOG2N, PIPE_LAT);
  localparam int FILL_W = $clog2(LAT + 1);

  localparam logic [FILL_W-1:0] LAT_F     = FILL_W'(LAT);
  localparam logic [FILL_W-1:0] DRAIN_END = FILL_W'(LAT - 1);
  localparam logic [LOG2N-1:0]  CNT_TOP   = LOG2N'(N - 1);

  fft_state_e        state_q, state_d;
  logic [LOG2N-1:0]  cnt_q, cnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] drain_q, drain_d;
  logic              pend_q, pend_d;
  logic              m_valid_q, m_valid_d;
  logic [LOG2N-1:0]  m_idx_q, m_idx_d;
  logic              ferr_q, ferr_d;

  logic              accept;
  logic              misalign;
  logic              pend_set;

`ifdef FFT_CTRL_AUTOFLUSH_EN
  logic              last_acc_q, last_acc_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    drain_d   = '0;
    pend_d    = 1'b0;
    m_valid_d = 1'b0;
    m_idx_d   = m_idx_q;
    ferr_d    = 1'b0;
    s_ready   = 1'b1;
    dp_en     = 1'b0;
    dp_flush  = 1'b0;
    accept    = 1'b0;
    misalign  = 1'b0;
    pend_set  = 1'b0;

    if (state_q == ST_FLUSH) begin
      // Draining: push zeros through every cycle, refuse new samples.
      s_ready  = 1'b0;
      dp_en    = 1'b1;
      dp_flush = 1'b1;
    end else begin
      accept = s_valid;
      dp_en  = s_valid;
    end

    // s_last must coincide exactly with the final index of a frame.
    misalign = accept && (s_last != (cnt_q == CNT_TOP));

    if (dp_en) begin
      cnt_d  = misalign ? '0 : cnt_q + LOG2N'(1);
      fill_d = FILL_W'(sat_inc(int'(fill_q), LAT));
    end

    // Only meaningful in RUN; IDLE and FLUSH never consult it.
    pend_set = pend_q || flush_req;
`ifdef FFT_CTRL_AUTOFLUSH_EN
    pend_set = pend_set || (last_acc_q && !s_valid);
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Look at the post-advance index so a flush requested with the last
        // sample enters FLUSH on the very next cycle.
        if (pend_set && (cnt_d == '0)) state_d = ST_FLUSH;
        else                           pend_d  = pend_set;
      end
      ST_FLUSH: begin
        drain_d = FILL_W'(sat_inc(int'(drain_q), LAT));
        if (drain_q == DRAIN_END) begin
          // Pipeline is empty again: restart fill and frame position.
          state_d = ST_IDLE;
          fill_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    m_valid_d = dp_en && (fill_q == LAT_F);
    if (m_valid_q) m_idx_d = m_idx_q + LOG2N'(1);
    ferr_d = misalign;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fill_q    <= '0;
      drain_q   <= '0;
      pend_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_idx_q   <= '0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      drain_q   <= drain_d;
      pend_q    <= pend_d;
      m_valid_q <= m_valid_d;
      m_idx_q   <= m_idx_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef FFT_CTRL_AUTOFLUSH_EN
  assign last_acc_d = accept && s_last;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) last_acc_q <= 1'b0;
    else           last_acc_q <= last_acc_d;
  end
`endif

  assign dp_cnt    = cnt_q;
  assign m_valid   = m_valid_q;
  assign m_idx     = m_idx_q;
  assign m_last    = m_valid_q && (m_idx_q == CNT_TOP);
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_fft_ctrl.sv
// tb/tb_fft_ctrl.sv - self-checking bench for fft_ctrl (LOG2N=6, PIPE_LAT=2)
module tb_fft_ctrl;

  localparam int LOG2N    = 6;
  localparam int PIPE_LAT = 2;
  localparam int N        = 64;
  localparam int LAT      = 65;
`ifdef FFT_CTRL_AUTOFLUSH_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  localparam int MD_IDLE  = 0;
  localparam int MD_RUN   = 1;
  localparam int MD_FLUSH = 2;

  logic             aclk      = 1'b0;
  logic             areset_n  = 1'b1;
  logic             s_valid   = 1'b0;
  logic             s_last    = 1'b0;
  logic             flush_req = 1'b0;
  logic             s_ready, dp_en, dp_flush, m_valid, m_last, frame_err;
  logic [LOG2N-1:0] dp_cnt, m_idx;

  int nvec = 0;
  int nerr = 0;

  // reference model (plain integers, spec-level rules)
  int md     = MD_IDLE;
  int pos    = 0;
  int fill   = 0;
  int drain  = 0;
  int outs   = 0;
  int npos   = 0;
  bit pend   = 1'b0;
  bit e_mv   = 1'b0;
  bit e_fe   = 1'b0;
  bit lastacc = 1'b0;
  bit acc, adv, bad;

  // observation tallies
  int en_cnt    = 0;
  int mv_cnt    = 0;
  int ml_cnt    = 0;
  int fe_cnt    = 0;
  int last_ml   = 0;
  int first_en  = -1;
  int first_idx = -1;

  fft_ctrl #(.LOG2N(LOG2N), .PIPE_LAT(PIPE_LAT)) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .flush_req (flush_req),
    .dp_en     (dp_en),
    .dp_cnt    (dp_cnt),
    .dp_flush  (dp_flush),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_idx     (m_idx),
    .frame_err (frame_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare on the falling edge, then advance the model with this cycle's inputs.
  always @(negedge aclk) begin
    if (!areset_n) begin
      md = MD_IDLE; pos = 0; fill = 0; drain = 0; outs = 0;
      pend = 1'b0; e_mv = 1'b0; e_fe = 1'b0; lastacc = 1'b0;
    end
    chk("s_ready",   int'(s_ready),   int'(md != MD_FLUSH));
    chk("dp_en",     int'(dp_en),     (md == MD_FLUSH) ? 1 : int'(s_valid));
    chk("dp_flush",  int'(dp_flush),  int'(md == MD_FLUSH));
    chk("dp_cnt",    int'(dp_cnt),    pos);
    chk("m_valid",   int'(m_valid),   int'(e_mv));
    chk("m_last",    int'(m_last),    int'(e_mv && ((outs % N) == N - 1)));
    chk("frame_err", int'(frame_err), int'(e_fe));
    if (e_mv) chk("m_idx", int'(m_idx), outs % N);

    if (m_valid && first_en < 0) begin
      first_en  = en_cnt;
      first_idx = int'(m_idx);
    end
    if (dp_en) en_cnt++;
    if (m_valid) begin
      mv_cnt++;
      last_ml = int'(m_last);
      if (m_last) ml_cnt++;
    end
    if (frame_err) fe_cnt++;

    if (areset_n) begin
      acc = (md != MD_FLUSH) && s_valid;
      adv = acc || (md == MD_FLUSH);
      bad = acc && (s_last != (pos == N - 1));
      if (e_mv) outs++;
      e_mv = adv && (fill >= LAT);
      e_fe = bad;
      npos = adv ? (bad ? 0 : (pos + 1) % N) : pos;
      if (adv) fill++;
      if (md == MD_IDLE) begin
        if (acc) md = MD_RUN;
      end else if (md == MD_RUN) begin
        if (flush_req) pend = 1'b1;
        if (AUTO != 0 && lastacc && !s_valid) pend = 1'b1;
        if (pend && npos == 0) begin
          md = MD_FLUSH; pend = 1'b0; drain = 0;
        end
      end else begin
        drain++;
        if (drain == LAT) begin
          md = MD_IDLE; fill = 0; npos = 0;
        end
      end
      pos = npos;
      lastacc = acc && s_last;
    end
  end

  task automatic cyc(input logic v, input logic l, input logic f);
    @(posedge aclk);
    #1;
    s_valid = v; s_last = l; flush_req = f;
    #2;
  endtask

  task automatic clr_tally();
    en_cnt = 0; mv_cnt = 0; ml_cnt = 0; fe_cnt = 0;
    last_ml = 0; first_en = -1; first_idx = -1;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #3;
    areset_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; flush_req = 1'b0;
    #1;
    chk("rst_m_valid",   int'(m_valid),   0);
    chk("rst_m_last",    int'(m_last),    0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_dp_cnt",    int'(dp_cnt),    0);
    chk("rst_m_idx",     int'(m_idx),     0);
    chk("rst_dp_flush",  int'(dp_flush),  0);
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int low;

    // fill latency: first output after 66 advances, index 0
    do_reset();
    clr_tally();
    cyc(1'b0, 1'b0, 1'b0);
    chk("s_ready_after_release", int'(s_ready), 1);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("first_mv_advances", first_en, 66);
    chk("first_mv_idx", first_idx, 0);

    // input gaps: dp_cnt holds, outputs follow the same spacing
    do_reset();
    for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1, 1'b0);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, i == N - 1, 1'b0);
      if (i == 11 || i == 31) chk("post_gap_m_valid", int'(m_valid), 0);
      if (i == 10 || i == 30) begin
        for (int j = 0; j < 3; j++) begin
          cyc(1'b0, 1'b0, 1'b0);
          chk("gap_dp_cnt", int'(dp_cnt), i + 1);
          chk("gap_dp_en", int'(dp_en), 0);
          chk("gap_m_valid", int'(m_valid), int'(j == 0));
        end
      end
    end

    // flush after two frames; flush_req while IDLE must be ignored
    do_reset();
    clr_tally();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1, 1'b0);
    for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1, i == 10);
    low = 0;
    for (int c = 0; c < 100; c++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (c == 0) begin
        chk("flush_entry_dp_flush", int'(dp_flush), 1);
        chk("flush_entry_dp_cnt", int'(dp_cnt), 0);
      end
      if (!s_ready) low++;
    end
    chk("s_ready_low_cycles", low, 65);
    chk("total_m_valid", mv_cnt, 128);
    chk("total_m_last", ml_cnt, 2);
    chk("final_m_last", last_ml, 1);

    // frame misalignment
    do_reset();
    clr_tally();
    for (int i = 0; i <= 40; i++) cyc(1'b1, i == 40, 1'b0);
    chk("err_not_yet", int'(frame_err), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("err_pulse_early_last", int'(frame_err), 1);
    chk("err_dp_cnt_restart", int'(dp_cnt), 0);
    for (int i = 1; i < N; i++) begin
      cyc(1'b1, i == N - 1, 1'b0);
      if (i == 1) chk("err_one_cycle", int'(frame_err), 0);
    end
    for (int i = 0; i < N; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("err_pulse_missing_last", int'(frame_err), 1);
    chk("err_dp_cnt_wrap", int'(dp_cnt), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("err_pulse_count", fe_cnt, 2);

    // flush_req with s_last, then reset in the middle of the drain
    do_reset();
    for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1, i == N - 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("sim_flush_dp_flush", int'(dp_flush), 1);
    chk("sim_flush_s_ready", int'(s_ready), 0);
    repeat (9) cyc(1'b0, 1'b0, 1'b0);
    chk("drain_m_valid", int'(m_valid), 1);
    areset_n = 1'b0;
    #1;
    chk("rst_in_flush_m_valid", int'(m_valid), 0);
    chk("rst_in_flush_dp_flush", int'(dp_flush), 0);
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_in_flush_s_ready", int'(s_ready), 1);
    clr_tally();
    for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("no_output_after_reset", mv_cnt, 0);

    // input idle after a frame: auto-drain only with the feature enabled
    do_reset();
    for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("auto_flush_entry", int'(dp_flush), AUTO);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("auto_flush_hold", int'(dp_flush), AUTO);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("run_then_flush_req", int'(dp_flush), 1);
    chk("run_then_flush_ready", int'(s_ready), 0);
    repeat (70) cyc(1'b0, 1'b0, 1'b0);
    chk("drain_done_idle", int'(dp_flush), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
